// File: rtl/aes_round_ctrl_if.sv
// Control interface of the AES-256 round controller.
// The key_rdy handshake line exists only when AES_ROUND_CTRL_KEY_WAIT_EN is defined.
interface aes_round_ctrl_if;
  logic       start;
  logic       abort;
`ifdef AES_ROUND_CTRL_KEY_WAIT_EN
  logic       key_rdy;
`endif
  logic [3:0] rnd_cnt;
  logic [2:0] step;
  logic       load;
  logic       mix_en;
  logic       last_rnd;
  logic       busy;
  logic       done;

  // Requester side: drives the commands and observes the controller outputs.
  modport master (
    output start,
    output abort,
`ifdef AES_ROUND_CTRL_KEY_WAIT_EN
    output key_rdy,
`endif
    input  rnd_cnt,
    input  step,
    input  load,
    input  mix_en,
    input  last_rnd,
    input  busy,
    input  done
  );

  // Controller side.
  modport slave (
    input  start,
    input  abort,
`ifdef AES_ROUND_CTRL_KEY_WAIT_EN
    input  key_rdy,
`endif
    output rnd_cnt,
    output step,
    output load,
    output mix_en,
    output last_rnd,
    output busy,
    output done
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-256 round sequencer: LOAD, 15 rounds x 5 steps, then a one-cycle FINISH
// that carries the done pulse. Abort and reset discard the block silently.
// Optional feature macro: AES_ROUND_CTRL_KEY_WAIT_EN adds the key_rdy stall
// at step 0 of every round.
module aes_round_ctrl (
  input  logic              clk,
  input  logic              reset,
  aes_round_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUND  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] rnd_cnt;
  logic [2:0] step;
  logic       load;
  logic       mix_en_base;
  logic       busy;
  logic       done;
  logic       stall;

  // MixColumns runs in the middle rounds only and never at the final step.
  function automatic logic mix_on(input logic [3:0] r, input logic [2:0] s);
    return (r >= 4'd1) && (r <= 4'd13) && (s <= 3'd3);
  endfunction

`ifdef AES_ROUND_CTRL_KEY_WAIT_EN
  assign stall = (state == ROUND) && (step == 3'd0) && !bus.key_rdy;
`else
  assign stall = 1'b0;
`endif

  // Sequencer state, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rnd_cnt     <= 4'd0;
      step        <= 3'd0;
      load        <= 1'b0;
      mix_en_base <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      load        <= 1'b0;
      done        <= 1'b0;
      mix_en_base <= 1'b0;
      case (state)
        IDLE: begin
          rnd_cnt <= 4'd0;
          step    <= 3'd0;
          if (bus.start && !bus.abort) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          rnd_cnt <= 4'd0;
          step    <= 3'd0;
          if (bus.abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ROUND;
            busy  <= 1'b1;
          end
        end
        ROUND: begin
          if (bus.abort) begin
            state   <= IDLE;
            rnd_cnt <= 4'd0;
            step    <= 3'd0;
            busy    <= 1'b0;
          end else if (stall) begin
            // Hold position until the round key words are valid.
            mix_en_base <= mix_on(rnd_cnt, step);
          end else if (step == 3'd4) begin
            step <= 3'd0;
            if (rnd_cnt == 4'd14) begin
              state   <= FINISH;
              rnd_cnt <= 4'd0;
              done    <= 1'b1;
            end else begin
              rnd_cnt     <= rnd_cnt + 4'd1;
              mix_en_base <= mix_on(rnd_cnt + 4'd1, 3'd0);
            end
          end else begin
            step        <= step + 3'd1;
            mix_en_base <= mix_on(rnd_cnt, step + 3'd1);
          end
        end
        FINISH: begin
          // Leaves unconditionally; a start seen here is dropped.
          state   <= IDLE;
          rnd_cnt <= 4'd0;
          step    <= 3'd0;
          busy    <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          rnd_cnt <= 4'd0;
          step    <= 3'd0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rnd_cnt  = rnd_cnt;
  assign bus.step     = step;
  assign bus.load     = load;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.mix_en   = mix_en_base && !stall;
  assign bus.last_rnd = (state == ROUND) && (rnd_cnt == 4'd14);

endmodule
